// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, oversample tick and byte handshake of the UART receiver
interface uart_rx_if;
  logic       bclkx8;
  logic       rxd;
  logic       rd_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       framing_err;
  logic       overrun_err;

  modport master (
    output bclkx8, rxd, rd_en,
    input  rx_data, rx_valid, parity_err, framing_err, overrun_err
  );

  modport slave (
    input  bclkx8, rxd, rd_en,
    output rx_data, rx_valid, parity_err, framing_err, overrun_err
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with optional parity, clocked by fclk, advanced by the bclkx8 tick
module uart_rx #(
  parameter int OVERSAMPLE = 8,
  parameter int PARITY     = 0
) (
  input  logic      fclk,
  input  logic      rst_n,
  uart_rx_if.slave  bus
);

  localparam int              CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]   HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1 = CW'(OVERSAMPLE - 1);
  localparam logic            ODD     = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          perr_q, perr_d;
  logic          rxd_m, rxd_s;
  logic          load;
  logic          frame_bad;

  logic [7:0]    data_q;
  logic          valid_q;
  logic          perr_out_q;
  logic          framing_q;
  logic          ovr_q;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= bus.rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
    end
  end

  // Every sampling point sits OVERSAMPLE ticks after the previous one, the
  // first being half a bit into the start bit.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    load      = 1'b0;
    frame_bad = 1'b0;
    if (bus.bclkx8) begin
      case (state_q)
        S_IDLE: begin
          if (!rxd_s) begin
            state_d = S_START;
            tick_d  = '0;
            perr_d  = 1'b0;
          end
        end
        S_START: begin
          if (tick_q == HALF_M1) begin
            tick_d = '0;
            if (!rxd_s) begin
              state_d = S_DATA;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_q == FULL_M1) begin
            tick_d  = '0;
            shift_d = {rxd_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_PAR: begin
          if (tick_q == FULL_M1) begin
            tick_d  = '0;
            perr_d  = (^shift_q) ^ rxd_s ^ ODD;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_q == FULL_M1) begin
            tick_d = '0;
            if (rxd_s) begin
              load    = 1'b1;
              state_d = S_IDLE;
            end else begin
              frame_bad = 1'b1;
              state_d   = S_WAIT_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          // A held-low line (break) must not be re-read as a stream of frames.
          if (rxd_s) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      framing_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      framing_q <= frame_bad;
      if (load && (!valid_q || bus.rd_en)) begin
        data_q     <= shift_q;
        perr_out_q <= perr_q;
        valid_q    <= 1'b1;
        ovr_q      <= 1'b0;
      end else if (load) begin
        ovr_q <= 1'b1;
      end else if (bus.rd_en && valid_q) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.parity_err  = perr_out_q;
  assign bus.framing_err = framing_q;
  assign bus.overrun_err = ovr_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: the receive-side consumer of the baud rate generator's oversample tick (bclkx8). It operates in the fclk domain and uses the 8x tick as a clock enable. The block deserialises 8N1 frames (optional parity) from the rxd line, LSB first, and presents each byte through a valid/read handshake. It also reports parity, framing and overrun errors.

Parameters:
OVERSAMPLE, 8, ticks per bit period; even, 4..16; counter width clog2(OVERSAMPLE)
PARITY, 0, 0 = none, 1 = even, 2 = odd

Ports:
fclk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
bclkx8  input  1  oversample enable tick, one fclk cycle wide, OVERSAMPLE per bit period
rxd  input  1  serial line, idle high, asynchronous to fclk
rd_en  input  1  consumer read strobe; clears rx_valid
rx_data  output  8  last good byte received
rx_valid  output  1  level; rx_data holds an unread byte
parity_err  output  1  parity mismatch for the byte in rx_data (valid while rx_valid)
framing_err  output  1  one-fclk pulse: stop bit sampled low
overrun_err  output  1  sticky: a byte completed while rx_valid=1 and rd_en=0

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counters=0, shift reg=0, sync flops=1, all outputs 0. Reset mid-frame abandons the frame; after release the receiver waits for a new falling edge.
- rxd passes through a 2-flop synchroniser (reset to 1). The FSM sees only rxd_s. All FSM/counter updates occur only on cycles with bclkx8=1, except handshake and output updates.
- IDLE: on a tick with rxd_s=0 -> START, tick_cnt=0.
- START: tick_cnt increments per tick. When tick_cnt reaches OVERSAMPLE/2-1 (mid start bit): if rxd_s=0 -> DATA, tick_cnt=0, bit_cnt=0; else (glitch) -> IDLE, no outputs.
- DATA: sample rxd_s when tick_cnt reaches OVERSAMPLE-1 (mid bit); shift right into bit 7, so bits arrive LSB first; tick_cnt=0; bit_cnt++. After the 8th sample -> PAR if PARITY!=0, else STOP.
- PAR: sample at the mid bit the same way. Computed error = (^data ^ pbit) for even parity; the inverse for odd. -> STOP.
- STOP: sample at the mid bit.
  - rxd_s=1: load the byte. The fclk cycle after the sampling tick, rx_data<=shift, parity_err<=computed, rx_valid<=1. -> IDLE. The receiver can accept the next start bit immediately.
  - rxd_s=0: framing_err pulses high for 1 fclk, the byte is discarded, rx_data/rx_valid are unchanged. -> WAIT_IDLE.
- WAIT_IDLE: stay until a tick with rxd_s=1, then -> IDLE. This prevents a break condition from being re-read as frames.
- Handshake:
  - rd_en=1 with rx_valid=1 clears rx_valid and overrun_err next cycle.
  - rd_en with rx_valid=0 is ignored.
- Simultaneous byte load and rd_en: the new byte is loaded, rx_valid stays 1, no overrun.
- Byte load while rx_valid=1 and rd_en=0: the old rx_data/parity_err are kept, the new byte is dropped, and overrun_err<=1 (sticky until rd_en).
- Latency: rx_valid rises 1 fclk after the stop-bit mid-sample tick, i.e. about 9.5 bit periods after the start edge (10.5 with parity) plus 2–3 fclk of synchroniser delay.
- rx_data changes only on a good-frame load when there is no overrun; it never shows partial shift contents.

Test Plan:
- Reset: PARITY=0, bclkx8 every 4 fclk. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop), no rd_en -> rx_data=0xA5, rx_valid=1 after stop mid-sample, parity_err=0, other errors 0. Then pulse rd_en -> rx_valid=0 next cycle.
- Back-to-back frames 0x00, 0xFF, 0x3C with rd_en pulsed after each valid -> three loads in order, no errors, no idle gap needed between frames.
- Glitch: rxd low for 2 ticks then high -> remains IDLE, rx_valid stays 0. Then a real frame 0x55 -> received correctly.
- Framing: send 0x81 with stop bit 0 -> framing_err 1-cycle pulse, rx_valid unchanged. Hold rxd low 20 bit periods -> no further frames. Release, then send 0x42 -> received.
- Overrun: receive 0x11, no read, then receive 0x22 -> rx_data=0x11, overrun_err=1. Then rd_en -> rx_valid=0, overrun_err=0.
- PARITY=1: 0x07 with parity bit 1 -> parity_err=0; 0x07 with parity bit 0 -> parity_err=1. Assert rst_n=0 mid-DATA -> all outputs 0 immediately; the next frame 0x99 is received cleanly.
